// File: rtl/serdesphy_ana_tx_driver_mlane.sv
// Multi-lane CML TX output stage model: shared power-state FSM, registered pads,
// swing/de-emphasis amplitude and loopback tap. Optional macro: SERDESPHY_TX_POL_INV_EN.
module serdesphy_ana_tx_driver_mlane #(
  parameter int unsigned LANES      = 4,
  parameter int unsigned AMP_W      = 3,
  parameter int unsigned SETTLE_CYC = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   iso_en,
  input  logic                   elec_idle,
  input  logic                   lpbk_en,
  input  logic [LANES-1:0]       lane_en,
  input  logic [LANES-1:0]       serial_data,
`ifdef SERDESPHY_TX_POL_INV_EN
  input  logic [LANES-1:0]       pol_inv,
`endif
  input  logic [AMP_W-1:0]       swing_code,
  input  logic [AMP_W-1:0]       deemph_code,
  output logic [LANES-1:0]       txp,
  output logic [LANES-1:0]       txn,
  output logic [LANES*AMP_W-1:0] tx_amp,
  output logic [LANES-1:0]       lpbk_data,
  output logic                   tx_ready
);

  typedef enum logic [1:0] {
    ST_OFF,
    ST_WAKE,
    ST_ACTIVE,
    ST_EIDLE
  } state_t;

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYC - 1);

  state_t state, state_nxt;
  logic [7:0] cnt, cnt_nxt;

  logic [LANES-1:0]       prev_bit, prev_bit_nxt;
  logic [LANES-1:0]       first_flag, first_flag_nxt;
  logic [LANES-1:0]       txp_nxt, txn_nxt, lpbk_nxt;
  logic [LANES*AMP_W-1:0] amp_nxt;
  logic [AMP_W-1:0]       amp_repeat;
  logic [LANES-1:0]       pol_mask;

`ifdef SERDESPHY_TX_POL_INV_EN
  assign pol_mask = pol_inv;
`else
  assign pol_mask = '0;
`endif

  // Repeated-bit amplitude saturates at zero instead of wrapping.
  assign amp_repeat = (swing_code > deemph_code) ? (swing_code - deemph_code) : '0;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (!enable || iso_en) begin
      state_nxt = ST_OFF;
      cnt_nxt   = '0;
    end else begin
      case (state)
        ST_OFF: begin
          if (!elec_idle) begin
            state_nxt = ST_WAKE;
            cnt_nxt   = SETTLE_LOAD;
          end
        end
        ST_WAKE: begin
          if (elec_idle) begin
            state_nxt = ST_EIDLE;
            cnt_nxt   = '0;
          end else if (cnt == '0) begin
            state_nxt = ST_ACTIVE;
          end else begin
            cnt_nxt = cnt - 8'd1;
          end
        end
        ST_ACTIVE: begin
          if (elec_idle) state_nxt = ST_EIDLE;
        end
        ST_EIDLE: begin
          if (!elec_idle) begin
            state_nxt = ST_WAKE;
            cnt_nxt   = SETTLE_LOAD;
          end
        end
        default: begin
          state_nxt = ST_OFF;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Pads are registered from the next state so they track the state register.
  always_comb begin
    txp_nxt        = '0;
    txn_nxt        = '0;
    amp_nxt        = '0;
    lpbk_nxt       = '0;
    prev_bit_nxt   = prev_bit;
    first_flag_nxt = first_flag;
    case (state_nxt)
      ST_WAKE: begin
        txn_nxt        = '1;
        first_flag_nxt = '1;
      end
      ST_ACTIVE: begin
        for (int unsigned i = 0; i < LANES; i++) begin
          if (lane_en[i]) begin
            prev_bit_nxt[i]   = serial_data[i];
            first_flag_nxt[i] = 1'b0;
            if (lpbk_en) begin
              lpbk_nxt[i] = serial_data[i];
            end else begin
              txp_nxt[i] = serial_data[i] ^ pol_mask[i];
              txn_nxt[i] = ~serial_data[i] ^ pol_mask[i];
              if (first_flag[i] || (serial_data[i] != prev_bit[i]))
                amp_nxt[i*AMP_W +: AMP_W] = swing_code;
              else
                amp_nxt[i*AMP_W +: AMP_W] = amp_repeat;
            end
          end
        end
      end
      default: begin
        first_flag_nxt = '1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_OFF;
      cnt        <= '0;
      txp        <= '0;
      txn        <= '1;
      tx_amp     <= '0;
      lpbk_data  <= '0;
      tx_ready   <= 1'b0;
      prev_bit   <= '0;
      first_flag <= '1;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      txp        <= txp_nxt;
      txn        <= txn_nxt;
      tx_amp     <= amp_nxt;
      lpbk_data  <= lpbk_nxt;
      tx_ready   <= (state_nxt == ST_ACTIVE);
      prev_bit   <= prev_bit_nxt;
      first_flag <= first_flag_nxt;
    end
  end

endmodule
